uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb_pkg.sv | 23 ++
 rtl/uart_tx_arb.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg
//   Shared types and constants for the UART transmit arbiter.
//   state_t    : arbiter FSM state encoding
//   req_id_t   : identifies which requester owns the transmitter
//   ACK_BYTES  : length in bytes of a command-acknowledge frame
//   FRAME_W    : width of the frame shift register (holds up to 4 bytes)
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    typedef enum logic {
        ACK = 1'b0,
        TEL = 1'b1
    } req_id_t;

    localparam int ACK_BYTES = 1;
    localparam int FRAME_W   = 32;

endpackage

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Arbitrates two frame sources (1-byte command acknowledge and multi-byte
//   telemetry) onto a single byte-wide UART transmitter. Whole frames are
//   granted round-robin and sent byte by byte, MSB byte first.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   ack_req    in   level request for an acknowledge frame
//   ack_byte   in   acknowledge payload, captured at grant
//   ack_done   out  one-cycle pulse, acknowledge frame finished
//   tel_req    in   level request for a telemetry frame
//   tel_data   in   telemetry payload (8*TEL_BYTES), captured at grant
//   tel_done   out  one-cycle pulse, telemetry frame finished
//   trmt       out  one-cycle start strobe to the transmitter
//   tx_data    out  byte presented to the transmitter
//   tx_done    in   transmitter byte-complete pulse
//   busy       out  a frame is in progress
//
// state | meaning
// IDLE  | no frame; grant a pending request
// SEND  | trmt strobe cycle for the current byte
// WAIT  | byte handed to transmitter, waiting for tx_done
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int TEL_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ack_req,
    input  logic [7:0]             ack_byte,
    output logic                   ack_done,
    input  logic                   tel_req,
    input  logic [8*TEL_BYTES-1:0] tel_data,
    output logic                   tel_done,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy
);

    // Telemetry payload is left-aligned in the frame register so the byte
    // on the wire is always the top byte, regardless of TEL_BYTES.
    localparam int TEL_SHIFT = FRAME_W - 8 * TEL_BYTES;

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   frame_q, frame_d;
    logic [2:0]           count_q, count_d;
    req_id_t              gnt_q, gnt_d;
    req_id_t              last_q, last_d;
    logic                 trmt_q, trmt_d;

    logic [FRAME_W-1:0]   tel_aligned;
    logic                 grant_tel;
    logic                 frame_end;

    always_comb begin
        tel_aligned = FRAME_W'(tel_data) << TEL_SHIFT;

        // On a tie, serve whoever was not served last.
        if (ack_req && tel_req) begin
            grant_tel = (last_q == ACK);
        end else begin
            grant_tel = tel_req;
        end

        frame_end = (state_q == WAIT) && tx_done && (count_q <= 3'd1);

        state_d = state_q;
        frame_d = frame_q;
        count_d = count_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        trmt_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ack_req || tel_req) begin
                    state_d = SEND;
                    trmt_d  = 1'b1;
                    if (grant_tel) begin
                        gnt_d   = TEL;
                        frame_d = tel_aligned;
                        count_d = 3'(TEL_BYTES);
                    end else begin
                        gnt_d   = ACK;
                        frame_d = {ack_byte, {(FRAME_W-8){1'b0}}};
                        count_d = 3'(ACK_BYTES);
                    end
                end
            end
            SEND: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (count_q > 3'd1) begin
                        frame_d = frame_q << 8;
                        count_d = count_q - 3'd1;
                        state_d = SEND;
                        trmt_d  = 1'b1;
                    end else begin
                        last_d  = gnt_q;
                        count_d = 3'd0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            frame_q <= '0;
            count_q <= 3'd0;
            gnt_q   <= ACK;
            last_q  <= TEL;
            trmt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            count_q <= count_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            trmt_q  <= trmt_d;
        end
    end

    assign trmt     = trmt_q;
    assign tx_data  = frame_q[FRAME_W-1 -: 8];
    assign busy     = (state_q != IDLE);
    // Done pulses follow tx_done in the same cycle.
    assign ack_done = frame_end && (gnt_q == ACK);
    assign tel_done = frame_end && (gnt_q == TEL);

endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;

    localparam int TB_TEL = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ack_req;
    logic [7:0]    ack_byte;
    logic          ack_done;
    logic          tel_req;
    logic [23:0]   tel_data;
    logic          tel_done;
    logic          trmt;
    logic [7:0]    tx_data;
    logic          tx_done;
    logic          busy;

    int            vectors     = 0;
    int            miscompares = 0;

    logic [7:0]    exp_bytes[$];
    bit            exp_done[$];
    logic [7:0]    cur_exp = 8'h00;
    bit            popped_id;

    typedef struct {
        bit          is_tel;
        logic [7:0]  ack_b;
        logic [23:0] tel_d;
        int          delay;
    } vec_t;

    vec_t vecs[6];

    uart_tx_arb #(.TEL_BYTES(TB_TEL)) dut (
        .clk      (clk),
        .rst      (rst),
        .ack_req  (ack_req),
        .ack_byte (ack_byte),
        .ack_done (ack_done),
        .tel_req  (tel_req),
        .tel_data (tel_data),
        .tel_done (tel_done),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every trmt and done pulse is matched against what was queued.
    always @(negedge clk) begin
        if (!rst) begin
            if (trmt) begin
                if (exp_bytes.size() == 0) begin
                    check("trmt_unexpected", 32'(trmt), 32'd0);
                end else begin
                    cur_exp = exp_bytes.pop_front();
                    check("tx_data", 32'(tx_data), 32'(cur_exp));
                end
            end
            if (ack_done || tel_done) begin
                check("done_exclusive", 32'(ack_done & tel_done), 32'd0);
                if (exp_done.size() == 0) begin
                    check("done_unexpected", 32'({ack_done, tel_done}), 32'd0);
                end else begin
                    popped_id = exp_done.pop_front();
                    check("done_id", 32'({ack_done, tel_done}), popped_id ? 32'd1 : 32'd2);
                end
            end
        end
    end

    task automatic push_ack(input logic [7:0] b);
        exp_bytes.push_back(b);
        exp_done.push_back(1'b0);
    endtask

    task automatic push_tel(input logic [23:0] d);
        exp_bytes.push_back(d[23:16]);
        exp_bytes.push_back(d[15:8]);
        exp_bytes.push_back(d[7:0]);
        exp_done.push_back(1'b1);
    endtask

    // Waits for trmt, holds tx_done off for 'delay' cycles, then pulses it.
    task automatic serve_byte(input int delay, input bit drop_ack, input bit drop_tel);
        int n = 0;
        @(negedge clk);
        while (!trmt && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!trmt) begin
            check("trmt_timeout", 32'(trmt), 32'd1);
            return;
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("tx_data_stable", 32'(tx_data), 32'(cur_exp));
            check("trmt_single", 32'(trmt), 32'd0);
        end
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
        if (drop_ack) ack_req = 1'b0;
        if (drop_tel) tel_req = 1'b0;
    endtask

    task automatic serve_frame(input int nbytes, input int delay, input bit drop_ack, input bit drop_tel);
        for (int b = 0; b < nbytes; b++) begin
            serve_byte(delay, (b == nbytes - 1) && drop_ack, (b == nbytes - 1) && drop_tel);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ack_req = 1'b0;
        tel_req = 1'b0;
        tx_done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = '{is_tel: 1'b0, ack_b: 8'hA5, tel_d: 24'h000000, delay: 9};
        vecs[1] = '{is_tel: 1'b1, ack_b: 8'h00, tel_d: 24'h123456, delay: 2};
        vecs[2] = '{is_tel: 1'b0, ack_b: 8'h00, tel_d: 24'h000000, delay: 0};
        vecs[3] = '{is_tel: 1'b1, ack_b: 8'h00, tel_d: 24'hFFFF00, delay: 1};
        vecs[4] = '{is_tel: 1'b0, ack_b: 8'hFF, tel_d: 24'h000000, delay: 3};
        vecs[5] = '{is_tel: 1'b1, ack_b: 8'h00, tel_d: 24'hA55A3C, delay: 0};

        rst      = 1'b1;
        ack_req  = 1'b0;
        tel_req  = 1'b0;
        ack_byte = 8'h00;
        tel_data = 24'h0;
        tx_done  = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_trmt", 32'(trmt), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_dones", 32'({ack_done, tel_done}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-requester frames; payload is scrambled right after grant.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (vecs[i].is_tel) begin
                tel_data = vecs[i].tel_d;
                tel_req  = 1'b1;
                push_tel(vecs[i].tel_d);
            end else begin
                ack_byte = vecs[i].ack_b;
                ack_req  = 1'b1;
                push_ack(vecs[i].ack_b);
            end
            @(posedge clk);
            #1;
            ack_byte = ~ack_byte;
            tel_data = ~tel_data;
            serve_frame(vecs[i].is_tel ? TB_TEL : 1, vecs[i].delay, !vecs[i].is_tel, vecs[i].is_tel);
            @(negedge clk);
            check("busy_after_frame", 32'(busy), 32'd0);
        end

        // Ack raised during a telemetry frame waits for tel_done.
        @(posedge clk);
        #1;
        tel_data = 24'h9ABCDE;
        tel_req  = 1'b1;
        push_tel(24'h9ABCDE);
        push_ack(8'h3C);
        serve_byte(1, 1'b0, 1'b0);
        ack_byte = 8'h3C;
        ack_req  = 1'b1;
        serve_byte(2, 1'b0, 1'b0);
        check("busy_mid_tel", 32'(busy), 32'd1);
        serve_byte(0, 1'b0, 1'b1);
        serve_frame(1, 1, 1'b1, 1'b0);
        @(negedge clk);
        check("busy_after_ack", 32'(busy), 32'd0);

        // tx_done in IDLE and in SEND is ignored.
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(negedge clk);
        check("idle_txdone_busy", 32'(busy), 32'd0);
        check("idle_txdone_dones", 32'({ack_done, tel_done}), 32'd0);
        @(posedge clk);
        #1;
        tx_done  = 1'b0;
        ack_byte = 8'h77;
        ack_req  = 1'b1;
        push_ack(8'h77);
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(negedge clk);
        check("send_trmt", 32'(trmt), 32'd1);
        check("send_dones", 32'({ack_done, tel_done}), 32'd0);
        @(posedge clk);
        #1 tx_done = 1'b0;
        @(negedge clk);
        check("send_ignored_busy", 32'(busy), 32'd1);
        check("send_ignored_trmt", 32'(trmt), 32'd0);
        @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        ack_req = 1'b0;
        @(negedge clk);
        check("busy_after_send_test", 32'(busy), 32'd0);

        // Reset during WAIT of telemetry byte 2.
        @(posedge clk);
        #1;
        tel_data = 24'h123456;
        tel_req  = 1'b1;
        push_tel(24'h123456);
        serve_byte(1, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        while (!trmt && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("byte2_trmt_seen", 32'(trmt), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_trmt", 32'(trmt), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_dones", 32'({ack_done, tel_done}), 32'd0);
        exp_bytes.delete();
        exp_done.delete();
        tel_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_idle", 32'(busy), 32'd0);
            check("post_rst_trmt", 32'(trmt), 32'd0);
        end

        // Round-robin from reset: both held, expect ack, tel, ack, tel.
        do_reset();
        @(posedge clk);
        #1;
        ack_byte = 8'h11;
        tel_data = 24'hAABBCC;
        ack_req  = 1'b1;
        tel_req  = 1'b1;
        push_ack(8'h11);
        push_tel(24'hAABBCC);
        push_ack(8'h11);
        push_tel(24'hAABBCC);
        serve_frame(1, 1, 1'b0, 1'b0);
        serve_frame(TB_TEL, 0, 1'b0, 1'b0);
        serve_frame(1, 2, 1'b1, 1'b0);
        serve_frame(TB_TEL, 1, 1'b0, 1'b1);
        @(negedge clk);
        check("rr_busy_end", 32'(busy), 32'd0);

        repeat (3) @(negedge clk);
        check("bytes_outstanding", 32'(exp_bytes.size()), 32'd0);
        check("dones_outstanding", 32'(exp_done.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
